uartrx: RTL and testbench
=========================

UARTRX -- requirements
Module: uartrx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 868, clk cycles per serial bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: rx  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-005 Port: dataout  output  8  last correctly received byte; holds until the next good frame.
REQ-006 Port: rdsig  output  1  one-cycle pulse; dataout is newly valid.
REQ-007 Port: frame_err  output  1  one-cycle pulse; the stop bit (or parity, see Configuration) was bad.
REQ-008 Port: idle  output  1  high while the FSM is in IDLE.

Function
REQ-009 rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value rxs (2-cycle input latency).
REQ-010 FSM states: IDLE, START, DATA, STOP (plus PARITY when enabled); a 16-bit baud counter and a 3-bit bit index.
REQ-011 IDLE: on a falling edge of rxs (previous 1, current 0), go to START and clear the baud counter.
REQ-012 START: at count CLKS_PER_BIT/2-1 (mid start bit), sample rxs; if 0, go to DATA and clear the counter; if 1 (glitch), return to IDLE with no output pulse.
REQ-013 DATA: every CLKS_PER_BIT cycles, sample rxs into shift register bit [index], LSB first; after index 7 go to STOP (or PARITY).
REQ-014 STOP: after CLKS_PER_BIT cycles, sample rxs; if 1, load dataout and pulse rdsig the next cycle; if 0, pulse frame_err the next cycle and leave dataout unchanged.
REQ-015 After the stop sample, the FSM shall return to IDLE immediately (mid stop bit) so a back-to-back frame start edge is not missed.
REQ-016 rdsig and frame_err shall never be high together, and each is exactly one cycle wide per frame.
REQ-017 A frame with rx held low through the stop bit (break) shall produce frame_err; IDLE then waits for rxs to go high before accepting a new falling edge.
REQ-018 The baud counter shall wrap to 0 at CLKS_PER_BIT-1 and never exceed it.
REQ-019 dataout shall change only in the same cycle that rdsig is asserted.

Reset
REQ-020 With rst_n=0 at a clk edge: state=IDLE, counters=0, synchronizer flops=1, dataout=8'h00, rdsig=0, frame_err=0, idle=1.
REQ-021 Reset asserted mid-frame shall abort the frame with no pulse; after release the block waits for a fresh falling edge.

Configuration
REQ-022 Macro UARTRX_PARITY_EN: when defined, frame is 8E1; a PARITY state after DATA samples bit 9 one CLKS_PER_BIT later.
REQ-023 With UARTRX_PARITY_EN: if the XOR of the 8 data bits and the parity bit is 1, the frame shall pulse frame_err (not rdsig) at stop-bit time, even if the stop bit is good.
REQ-024 Without UARTRX_PARITY_EN: no PARITY state exists and the frame is 8N1 exactly as in REQ-013..014.

Verification (CLKS_PER_BIT=16 for sim)
REQ-025 Send 8'hA5 as 8N1 -> rdsig pulses once, dataout=8'hA5, frame_err stays 0, idle returns 1.
REQ-026 Send 8'h3C then 8'hC3 back-to-back with no idle gap -> two rdsig pulses, dataout 8'h3C then 8'hC3.
REQ-027 Drive rx low for 4 cycles, then high -> no rdsig or frame_err, FSM back in IDLE, idle=1.
REQ-028 Send 8'h55 with the stop bit forced 0 -> frame_err pulses once, rdsig stays 0, dataout keeps its previous value.
REQ-029 Assert rst_n=0 at data bit 3 of 8'hFF, release, then send 8'h12 -> no output for the aborted frame, then dataout=8'h12 with one rdsig.
REQ-030 With UARTRX_PARITY_EN: send 8'h07 with parity 1 -> rdsig, dataout=8'h07; send it with parity 0 -> frame_err only.

Source files
------------

// File: rtl/uartrx.sv
// UART receiver, 8N1 with 2-flop rx synchronizer and mid-bit sampling.
// Define UARTRX_PARITY_EN for 8E1 framing with a parity check.
module uartrx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] dataout,
    output logic       rdsig,
    output logic       frame_err,
    output logic       idle
);

`ifdef UARTRX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;
`endif

    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dataout_q, dataout_d;
    logic        rdsig_q, rdsig_d;
    logic        ferr_q, ferr_d;
    logic        meta_q, meta_d;
    logic        rxs_q, rxs_d;
    logic        rxs_prev_q, rxs_prev_d;
    logic        par_q, par_d;
    logic        bit_done;
    logic        frame_ok;

    assign bit_done = (cnt_q == LAST);

`ifdef UARTRX_PARITY_EN
    assign frame_ok = rxs_q & ~(^shift_q ^ par_q);
`else
    assign frame_ok = rxs_q;
`endif

    always_comb begin
        meta_d     = rx;
        rxs_d      = meta_q;
        rxs_prev_d = rxs_q;
        state_d    = state_q;
        cnt_d      = bit_done ? 16'd0 : cnt_q + 16'd1;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        dataout_d  = dataout_q;
        rdsig_d    = 1'b0;
        ferr_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                // a line held low (break) never re-arms until it rises
                if (rxs_prev_q && !rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d   = 16'd0;
                    state_d = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d[idx_q] = rxs_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UARTRX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UARTRX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    par_d   = rxs_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // leave mid stop bit so a back-to-back start edge is seen
                if (bit_done) begin
                    state_d = S_IDLE;
                    if (frame_ok) begin
                        rdsig_d   = 1'b1;
                        dataout_d = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            idx_q      <= 3'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            dataout_q  <= 8'h00;
            rdsig_q    <= 1'b0;
            ferr_q     <= 1'b0;
            meta_q     <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            dataout_q  <= dataout_d;
            rdsig_q    <= rdsig_d;
            ferr_q     <= ferr_d;
            meta_q     <= meta_d;
            rxs_q      <= rxs_d;
            rxs_prev_q <= rxs_prev_d;
        end
    end

    assign dataout   = dataout_q;
    assign rdsig     = rdsig_q;
    assign frame_err = ferr_q;
    assign idle      = (state_q == S_IDLE);

endmodule

// File: tb/tb_uartrx.sv
// Randomized bench for uartrx against a frame-level outcome model.
// Build with +define+UARTRX_PARITY_EN to exercise 8E1 framing.
module tb_uartrx;

    localparam int CPB = 16;
`ifdef UARTRX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] dataout;
    logic       rdsig;
    logic       frame_err;
    logic       idle;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_rdsig = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] prev_dout = 8'h00;

    uartrx #(.CLKS_PER_BIT(CPB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .dataout  (dataout),
        .rdsig    (rdsig),
        .frame_err(frame_err),
        .idle     (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rdsig || frame_err) begin
                check("overlap", 32'(rdsig & frame_err), 0);
                check("width", 32'(rdsig ? prev_rdsig : prev_ferr), 0);
                got_q.push_back({frame_err, frame_err ? 8'h00 : dataout});
            end
            if (dataout != prev_dout) check("dout_upd", 32'(rdsig), 1);
        end
        prev_rdsig = rdsig;
        prev_ferr  = frame_err;
        prev_dout  = dataout;
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame and records its expected outcome; rx is left
    // at the stop-bit level for the caller to manage.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input logic par);
        logic bad;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        if (PAR_EN) hold(par, CPB);
        hold(stop, CPB);
        bad = !stop || (PAR_EN && ((^b) ^ par));
        if (bad) begin
            exp_q.push_back(9'h100);
        end else begin
            exp_q.push_back({1'b0, b});
            last_good = b;
        end
    endtask

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction

    task automatic settle(input string tag);
        int n;
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
        check({tag, "_idle"}, 32'(idle), 1);
        check({tag, "_dout"}, 32'(dataout), 32'(last_good));
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        logic       par;
        repeat (4) @(negedge clk);
        check("rst_idle", 32'(idle), 1);
        check("rst_dout", 32'(dataout), 0);
        check("rst_rdsig", 32'(rdsig), 0);
        check("rst_ferr", 32'(frame_err), 0);
        rst_n = 1'b1;
        hold(1'b1, 2 * CPB);

        send_frame(8'hA5, 1'b1, even_par(8'hA5));
        settle("a5");

        send_frame(8'h3C, 1'b1, even_par(8'h3C));
        send_frame(8'hC3, 1'b1, even_par(8'hC3));
        settle("b2b");

        hold(1'b0, 4);
        hold(1'b1, 2);
        settle("glitch");

        send_frame(8'h55, 1'b0, even_par(8'h55));
        settle("badstop");

        send_frame(8'h00, 1'b0, 1'b0);
        hold(1'b0, 3 * CPB);
        hold(1'b1, 4);
        send_frame(8'h81, 1'b1, even_par(8'h81));
        settle("break");

        hold(1'b0, CPB);
        hold(1'b1, 3 * CPB + CPB / 2);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_good = 8'h00;
        hold(1'b1, 5 * CPB);
        settle("abort");
        send_frame(8'h12, 1'b1, even_par(8'h12));
        settle("after_rst");

`ifdef UARTRX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        settle("par_good");
        send_frame(8'h07, 1'b1, 1'b0);
        settle("par_bad");
`endif

        for (int k = 0; k < 30; k++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            par  = even_par(b) ^ ($urandom_range(0, 5) == 0);
            send_frame(b, stop, par);
            if (!stop) hold(1'b1, $urandom_range(3, 8));
            else if ($urandom_range(0, 1) == 1) hold(1'b1, $urandom_range(1, 6));
            if ($urandom_range(0, 7) == 0) begin
                hold(1'b0, $urandom_range(1, 4));
                hold(1'b1, CPB);
            end
        end
        settle("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
